// File: rtl/vga_frame_master_pkg.sv
// vga_pkg: shared FSM states, CSR offsets and pixel-word field layout for the frame master
package vga_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_PIX, DONE} state_t;
  localparam logic [3:0] CSR_CTRL = 4'd0;
  localparam logic [3:0] CSR_SRC = 4'd1;
  localparam logic [3:0] CSR_DST = 4'd2;
  localparam int Y_LSB = 24;
  localparam int Y_W = 7;
  localparam int X_LSB = 16;
  localparam int X_W = 8;
  localparam int PIX_LSB = 0;
  localparam int PIX_W = 8;
  localparam int LANE_W = 2;
  function automatic logic [31:0] pack_pixel(input logic [Y_W-1:0] y, input logic [X_W-1:0] x, input logic [PIX_W-1:0] p);
    return (32'(y) << Y_LSB) | (32'(x) << X_LSB) | (32'(p) << PIX_LSB);
  endfunction
endpackage

// File: rtl/vga_frame_master_if.sv
// vga_frame_master_if: CSR slave port and Avalon-MM master port of the frame master
interface vga_frame_master_if;
  logic [3:0] slave_address;
  logic slave_read;
  logic [31:0] slave_readdata;
  logic slave_write;
  logic [31:0] slave_writedata;
  logic slave_waitrequest;
  logic [31:0] master_address;
  logic master_read;
  logic [31:0] master_readdata;
  logic master_readdatavalid;
  logic master_write;
  logic [31:0] master_writedata;
  logic master_waitrequest;
  modport master (
    input slave_address, slave_read, slave_write, slave_writedata,
    input master_readdata, master_readdatavalid, master_waitrequest,
    output slave_readdata, slave_waitrequest,
    output master_address, master_read, master_write, master_writedata
  );
  modport slave (
    output slave_address, slave_read, slave_write, slave_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input slave_readdata, slave_waitrequest,
    input master_address, master_read, master_write, master_writedata
  );
endinterface

// File: rtl/vga_frame_master_pixel_scan.sv
// pixel_scan: row-major x/y position plus byte-lane counter for the pixel currently being written
module pixel_scan
  import vga_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [LANE_W-1:0] lane,
  output logic last
);
  logic x_end;
  assign x_end = x == X_W'(WIDTH - 1);
  assign last = x_end && y == Y_W'(HEIGHT - 1);
  // step one pixel per accepted write, wrapping x at the row end
  always_ff @(posedge clk)
    if (!reset_n || clr) begin
      x <= '0;
      y <= '0;
      lane <= '0;
    end else if (adv) begin
      lane <= lane + 1'b1;
      x <= x_end ? '0 : x + 1'b1;
      y <= x_end ? y + 1'b1 : y;
    end
endmodule

// File: rtl/vga_frame_master.sv
// vga_frame_master: reads a packed 8-bit frame word by word and writes each pixel to a VGA slave
module vga_frame_master
  import vga_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120
) (
  input logic clk,
  input logic reset_n,
  vga_frame_master_if.master bus
);
  state_t state, state_nx;
  logic [31:0] csr_src, csr_dst, ptr, cap, addr, wdata;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [LANE_W-1:0] lane;
  logic last, start, clr, accept, rd, wr;
  assign start = bus.slave_write && bus.slave_address == CSR_CTRL;
  assign clr = state == IDLE && start;
  assign accept = state == WR_PIX && !bus.master_waitrequest;
  pixel_scan #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan (
    .clk(clk), .reset_n(reset_n), .clr(clr), .adv(accept),
    .x(x), .y(y), .lane(lane), .last(last)
  );
  // state register
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nx;
  // CSRs only change while idle; the pointer walks the source frame a word at a time
  always_ff @(posedge clk)
    if (!reset_n) begin
      csr_src <= '0;
      csr_dst <= '0;
      ptr <= '0;
      cap <= '0;
    end else begin
      if (state == IDLE && bus.slave_write && bus.slave_address == CSR_SRC) csr_src <= bus.slave_writedata;
      if (state == IDLE && bus.slave_write && bus.slave_address == CSR_DST) csr_dst <= bus.slave_writedata;
      if (clr) ptr <= csr_src;
      else if (accept && lane == 2'd3) ptr <= ptr + 32'd4;
      if (state == RD_WAIT && bus.master_readdatavalid) cap <= bus.master_readdata;
    end
  // next state and raw bus request; requests stay asserted while the interconnect stalls
  always_comb begin
    state_nx = state;
    rd = 1'b0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    unique case (state)
      IDLE: state_nx = start ? RD_REQ : IDLE;
      RD_REQ: begin
        rd = 1'b1;
        addr = ptr;
        state_nx = bus.master_waitrequest ? RD_REQ : RD_WAIT;
      end
      RD_WAIT: state_nx = bus.master_readdatavalid ? WR_PIX : RD_WAIT;
      WR_PIX: begin
        wr = 1'b1;
        addr = csr_dst;
        wdata = pack_pixel(y, x, cap[{lane, 3'b000} +: 8]);
        state_nx = !accept ? WR_PIX : last ? DONE : lane == 2'd3 ? RD_REQ : WR_PIX;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.master_read = reset_n && rd;
  assign bus.master_write = reset_n && wr;
  assign bus.master_address = reset_n ? addr : '0;
  assign bus.master_writedata = reset_n ? wdata : '0;
  assign bus.slave_waitrequest = reset_n && start && state != DONE;
  assign bus.slave_readdata = reset_n && bus.slave_read ?
    (bus.slave_address == CSR_CTRL ? {31'b0, state != IDLE} :
     bus.slave_address == CSR_SRC ? csr_src :
     bus.slave_address == CSR_DST ? csr_dst : '0) : '0;
endmodule

// File: tb/tb_vga_frame_master.sv
// tb_vga_frame_master: scoreboard bench for the frame master with a latency/stall memory model
module tb_vga_frame_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  vga_frame_master_if bus ();
  vga_frame_master #(.WIDTH(160), .HEIGHT(120)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  int wcount = 0;
  int rcount = 0;
  logic [31:0] wlog[32768];
  int wcyc[32768];
  int cyc = 0;
  bit stall = 1'b0;
  int flush_gen = 0;
  int lat = 0;
  bit pend = 1'b0;
  logic [31:0] ra = '0;
  bit pw = 1'b0;
  bit pr = 1'b0;
  logic [31:0] pa = '0;
  logic [31:0] pd = '0;
  int seen = 0;
  logic [63:0] e;
  logic [31:0] d;
  int base, rbase, n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int p);
    int x, y, w, i;
    logic [7:0] b;
    x = p % 160;
    y = p / 160;
    w = p / 4;
    i = p % 4;
    b = 8'(8'h11 * (i + 1) + w);
    return {1'b0, 7'(y), 8'(x), 8'h00, b};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] r;
    w = (a - 32'h1000) >> 2;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(8'h11 * (i + 1) + w);
    return r;
  endfunction

  task automatic csr_write(input logic [3:0] a, input logic [31:0] v, input int bound);
    int k;
    @(posedge clk); #1;
    bus.slave_address = a;
    bus.slave_writedata = v;
    bus.slave_write = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.slave_waitrequest && k < bound);
    if (bus.slave_waitrequest) chk("csr_write_complete", 32'(bus.slave_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    bus.slave_address = a;
    bus.slave_read = 1'b1;
    @(negedge clk);
    v = bus.slave_readdata;
    @(posedge clk); #1;
    bus.slave_read = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory: accepts one read, answers after 1 cycle (or 1-5 when stalling), random waitrequest
  initial begin
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.master_read && !bus.master_waitrequest) begin
        pend = 1'b1;
        lat = stall ? int'($urandom_range(1, 5)) : 1;
        ra = bus.master_address;
      end
      @(posedge clk); #1;
      bus.master_readdatavalid = 1'b0;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          bus.master_readdatavalid = 1'b1;
          bus.master_readdata = mem_word(ra);
          pend = 1'b0;
        end
      end
      bus.master_waitrequest = stall ? 1'($urandom % 2) : 1'b0;
    end
  end

  // monitor: stall stability, read/write exclusion, and in-order write scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (seen != flush_gen) begin
        exp_q.delete();
        seen = flush_gen;
      end
      if (!reset_n) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        if (bus.master_read && bus.master_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
        if (pw) begin
          chk("wr_hold", 32'(bus.master_write), 32'd1);
          chk("wr_addr_hold", bus.master_address, pa);
          chk("wr_data_hold", bus.master_writedata, pd);
        end
        if (pr) begin
          chk("rd_hold", 32'(bus.master_read), 32'd1);
          chk("rd_addr_hold", bus.master_address, pa);
        end
        pw = bus.master_write && bus.master_waitrequest;
        pr = bus.master_read && bus.master_waitrequest;
        pa = bus.master_address;
        pd = bus.master_writedata;
        if (bus.master_read && !bus.master_waitrequest) rcount++;
        if (bus.master_write && !bus.master_waitrequest) begin
          if (exp_q.size() == 0) chk("write_expected", 32'd0, 32'd1);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.master_address, e[63:32]);
            chk("wr_data", bus.master_writedata, e[31:0]);
          end
          wlog[wcount] = bus.master_writedata;
          wcyc[wcount] = cyc;
          wcount++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.slave_address = 4'd0;
    bus.slave_writedata = '0;
    bus.slave_write = 1'b1;
    bus.slave_read = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_master_read", 32'(bus.master_read), 32'd0);
    chk("rst_master_write", 32'(bus.master_write), 32'd0);
    chk("rst_master_address", bus.master_address, 32'd0);
    chk("rst_master_writedata", bus.master_writedata, 32'd0);
    chk("rst_slave_readdata", bus.slave_readdata, 32'd0);
    chk("rst_slave_waitrequest", 32'(bus.slave_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
    bus.slave_read = 1'b0;
    reset_n = 1'b1;
    csr_read(4'd0, d); chk("idle_busy", d, 32'd0);
    csr_read(4'd1, d); chk("rst_csr1", d, 32'd0);
    csr_write(4'd1, 32'h1000, 4);
    csr_write(4'd2, 32'h2000, 4);
    csr_read(4'd1, d); chk("csr1_rb", d, 32'h1000);
    csr_read(4'd2, d); chk("csr2_rb", d, 32'h2000);

    stall = 1'b1;
    base = wcount;
    for (int p = 0; p < 200; p++) exp_q.push_back({32'h2000, exp_pix(p)});
    @(posedge clk); #1;
    bus.slave_address = 4'd0;
    bus.slave_write = 1'b1;
    @(negedge clk);
    chk("start_waitreq", 32'(bus.slave_waitrequest), 32'd1);
    n = 0;
    while (wcount - base < 40 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.slave_address = 4'd1;
    bus.slave_writedata = 32'hDEADBEEF;
    @(negedge clk);
    chk("busy_csr1_waitreq", 32'(bus.slave_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
    bus.slave_read = 1'b1;
    bus.slave_address = 4'd0;
    @(negedge clk);
    chk("busy_flag", bus.slave_readdata, 32'd1);
    @(posedge clk); #1;
    bus.slave_address = 4'd1;
    @(negedge clk);
    chk("csr1_unchanged", bus.slave_readdata, 32'h1000);
    @(posedge clk); #1;
    bus.slave_read = 1'b0;
    bus.slave_address = 4'd0;
    bus.slave_write = 1'b1;
    @(negedge clk);
    chk("start_still_held", 32'(bus.slave_waitrequest), 32'd1);
    n = 0;
    while (wcount - base < 170 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_writes_170", 32'(wcount - base), 32'd170);
    chk("stall_w0", wlog[base], 32'h00000011);
    chk("stall_w1", wlog[base + 1], 32'h00010022);
    chk("stall_w2", wlog[base + 2], 32'h00020033);
    chk("stall_w3", wlog[base + 3], 32'h00030044);
    chk("stall_row_end", wlog[base + 159], 32'h009F006B);
    chk("stall_row_wrap", wlog[base + 160], 32'h01000039);
    reset_n = 1'b0;
    bus.slave_write = 1'b0;
    flush_gen++;
    @(negedge clk);
    chk("abort_wr_drop", 32'(bus.master_write), 32'd0);
    chk("abort_addr_zero", bus.master_address, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rd_idle", 32'(bus.master_read), 32'd0);
    chk("abort_wr_idle", 32'(bus.master_write), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stall = 1'b0;
    csr_read(4'd1, d); chk("abort_csr1_cleared", d, 32'd0);
    csr_read(4'd0, d); chk("abort_idle", d, 32'd0);

    csr_write(4'd1, 32'h1000, 4);
    csr_write(4'd2, 32'h2000, 4);
    base = wcount;
    rbase = rcount;
    for (int p = 0; p < 19200; p++) exp_q.push_back({32'h2000, exp_pix(p)});
    csr_write(4'd0, 32'd0, 40000);
    chk("frame_reads", 32'(rcount - rbase), 32'd4800);
    chk("frame_writes", 32'(wcount - base), 32'd19200);
    chk("frame_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_w0", wlog[base], 32'h00000011);
    chk("frame_w3", wlog[base + 3], 32'h00030044);
    chk("frame_row_end", wlog[base + 159], 32'h009F006B);
    chk("frame_row_wrap", wlog[base + 160], 32'h01000039);
    chk("frame_last", wlog[base + 19199], 32'h779F0003);
    chk("lane_spacing", 32'(wcyc[base + 1] - wcyc[base]), 32'd1);
    chk("word_period", 32'(wcyc[base + 4] - wcyc[base]), 32'd6);
    csr_read(4'd0, d); chk("done_busy", d, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_frame_master.md
VGA_FRAME_MASTER -- requirements
Module: vga_frame_master

Interface
REQ-001 SHALL have parameter WIDTH, default 160, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 120, frame height in pixels.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port slave_address  input  4  CSR word select.
REQ-006 SHALL have port slave_read  input  1  CSR read strobe.
REQ-007 SHALL have port slave_readdata  output  32  CSR read data.
REQ-008 SHALL have port slave_write  input  1  CSR write strobe.
REQ-009 SHALL have port slave_writedata  input  32  CSR write data.
REQ-010 SHALL have port slave_waitrequest  output  1  stalls the host's CSR write.
REQ-011 SHALL have port master_address  output  32  Avalon-MM byte address.
REQ-012 SHALL have port master_read  output  1  memory read request.
REQ-013 SHALL have port master_readdata  input  32  memory read data.
REQ-014 SHALL have port master_readdatavalid  input  1  read data qualifier.
REQ-015 SHALL have port master_write  output  1  pixel write request.
REQ-016 SHALL have port master_writedata  output  32  packed pixel word.
REQ-017 SHALL have port master_waitrequest  input  1  interconnect stall.

Function
REQ-018 SHALL implement these CSRs: word 1 = source frame byte address (R/W); word 2 = VGA slave byte address (R/W); write to word 0 = start; read of word 0 = {31'b0, busy}.
REQ-019 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_PIX, DONE.
REQ-020 SHALL, in IDLE, on slave_write with slave_address=0, clear x, y and lane, load the word pointer from CSR1, and enter RD_REQ.
REQ-021 SHALL hold slave_waitrequest=1 from the start write until the DONE cycle, and drop it to 0 in DONE so the start write completes exactly once.
REQ-022 SHALL ignore writes to words 1 and 2 while busy; such writes complete with waitrequest=0.
REQ-023 SHALL, in RD_REQ, drive master_read=1 with master_address=word pointer, hold both stable while master_waitrequest=1, and move to RD_WAIT on the first cycle master_waitrequest=0.
REQ-024 SHALL, in RD_WAIT, capture master_readdata on master_readdatavalid=1 and enter WR_PIX; readdata arriving while not in RD_WAIT is ignored.
REQ-025 SHALL, in WR_PIX, emit 4 writes, one per byte lane 0..3 (little-endian: lane i holds pixel 4k+i), to master_address=CSR2.
REQ-026 SHALL pack master_writedata as [30:24]=y, [23:16]=x, [7:0]=lane byte, with all other bits 0.
REQ-027 SHALL hold master_write, master_address and master_writedata stable while master_waitrequest=1, and advance the lane, x and y only on an accepted write.
REQ-028 SHALL scan pixels row-major: x increments; at x=WIDTH-1, x wraps to 0 and y increments.
REQ-029 SHALL, after lane 3 is accepted, add 4 to the word pointer and return to RD_REQ, unless the accepted pixel was (WIDTH-1, HEIGHT-1); in that case it SHALL enter DONE.
REQ-030 SHALL go from DONE to IDLE on the next cycle.
REQ-031 SHALL never assert master_read and master_write together, and SHALL never emit a pixel with x≥WIDTH or y≥HEIGHT.
REQ-032 SHALL complete a 160x120 frame in 4800 reads and 19200 writes.
REQ-033 SHALL, with zero stalls and 1-cycle read latency, take 6 cycles per word: RD_REQ 1 cycle, RD_WAIT 1 cycle, WR_PIX 4 cycles.

Reset
REQ-034 SHALL, while reset_n=0 at a clk edge, enter IDLE and clear CSR1, CSR2, x, y, lane, the pointer and the capture register to 0.
REQ-035 SHALL hold these outputs at 0 during reset: master_read, master_write, master_address, master_writedata, slave_readdata, slave_waitrequest.
REQ-036 SHALL, on reset mid-frame, abandon the transfer; a read response arriving after reset SHALL be ignored.

Structure
REQ-037 SHALL take the state enum, the CSR offset localparams and the pixel-packing field positions from shared package vga_pkg.
REQ-038 SHALL be a single module with no sub-modules; the x/y/lane scan counter MAY be a sub-module named pixel_scan.

Verification
REQ-039 Bench SHALL cover: CSR1=0x1000, CSR2=0x2000, start, memory word 0x1000=0x44332211, no stalls -> writes 0x00000011, 0x00010022, 0x00020033, 0x00030044 to 0x2000.
REQ-040 Bench SHALL cover: full frame -> 4800 reads, 19200 writes, last word 0x779F00xx, then slave_waitrequest drops and busy reads 0.
REQ-041 Bench SHALL cover: random master_waitrequest 50% plus read latency 1-5 cycles -> identical write sequence, with signals held stable through stalls.
REQ-042 Bench SHALL cover: row wrap with word 39 (pixels 156-159) -> 4th write x=159,y=0; next write x=0,y=1.
REQ-043 Bench SHALL cover: reset_n=0 in WR_PIX after 2 lanes -> next cycle master_write=0, IDLE; restart redraws from (0,0).
REQ-044 Bench SHALL cover: write to CSR1 while busy -> value unchanged and the transfer unaffected.
